opb_register_bank_ppc2simulink: RTL and testbench
=================================================

Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor to the single-register OPB-to-Simulink software register.
- Exposes C_NUM_REGS 32-bit registers behind one OPB slave window, with per-register read-only mode, byte-enable writes and per-register write strobes.
- Sits between the PPC OPB bus and user fabric logic; user logic runs on OPB_Clk, so no CDC.

Parameters:
- C_BASEADDR, 32'h01010000, first byte address of the window
- C_HIGHADDR, 32'h010100FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width; only 32 is supported
- C_NUM_REGS, 4, number of registers, 1..64; must satisfy 4*C_NUM_REGS <= window size
- C_RO_MASK, 0, bit i=1 makes register i read-only (reads user_data_in slice i)
- C_RESET_VAL, 32'h0, reset value of every writable register
- C_FAMILY, "virtex6", informational only

Ports:
- OPB_Clk  in  1  single clock for bus and user side
- OPB_Rst_n  in  1  asynchronous active-low reset
- OPB_ABus  in  [0:31]  address, big-endian bit order
- OPB_BE  in  [0:3]  byte enables; BE[0] = bus bits [0:7] = user bits [31:24]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; zero outside the ack cycle
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_out  out  32*C_NUM_REGS  register i at bits [32i+31:32i]
- user_data_in  in  32*C_NUM_REGS  read-only sources; slices of writable registers are ignored
- user_wr_strobe  out  C_NUM_REGS  bit i pulses one cycle when register i is updated
- user_commit  in  1  used only with the optional feature; ignored otherwise

Behaviour:
- Reset (async assert, sync release): writable regs = C_RESET_VAL; read-only slices of user_data_out = 0; Sl_DBus = 0; Sl_xferAck = 0; user_wr_strobe = 0; FSM in IDLE.
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word index = (OPB_ABus - C_BASEADDR) >> 2.
- FSM IDLE: on a hit, register RNW, BE, DBus and index, then go to ACK.
- FSM ACK: Sl_xferAck=1 for exactly one cycle (latency: ack in the 2nd cycle of select); perform the write / drive read data; return to IDLE.
- Select held high continuously: one transfer is acked every 2 cycles.
- Select dropped while in ACK: the transfer still completes (bus abort is the master's problem).
- Write to a writable index: update only the bytes whose BE is set. BE=0000 is acked, leaves data unchanged, and still pulses the strobe.
- Strobe timing: user_wr_strobe[i] is high in the cycle after ACK; user_data_out is valid in the same cycle.
- Write to a read-only index, or to index >= C_NUM_REGS: acked, data dropped, no strobe.
- Read: Sl_DBus = register value, or the user_data_in slice for read-only indices, during the ACK cycle only; index >= C_NUM_REGS reads 0. Reads ignore BE.
- Read-only slices of user_data_out are driven with a registered copy of user_data_in (one-cycle delay).
- Miss (address outside window): no response; outputs stay 0.
- Reset asserted mid-transfer: immediate return to reset values; no ack is issued.

Optional Feature:
- Macro OPB_REGBANK_SHADOW_EN.
- Defined:
  - OPB writes land in shadow registers; readback returns the shadow.
  - user_data_out loads all shadows in the cycle after user_commit=1.
  - user_wr_strobe pulses at that load, only for registers written since the last commit (dirty bits); dirty bits are then cleared.
  - If a commit and an OPB write occur in the same cycle: the write's register stays dirty with its new shadow value, and user_data_out takes the pre-write shadow.
- Undefined: no shadows; behaviour as described above.

Decomposition:
- Package opb_regbank_pkg:
  - FSM state enum (IDLE, ACK)
  - byte-lane mapping function (BE to user byte mask)
  - constant for the word address shift (2)
- One natural sub-module: opb_regbank_slave (decode, FSM, ack/data mux). Register array and strobes stay in the top.

Test Plan:
- Reset, then read regs 0..3 with C_RESET_VAL=32'hA5A5_0000 -> each Sl_DBus=0xA5A50000; xferAck exactly 1 cycle, in the 2nd select cycle.
- Write 0xDEADBEEF to 0x01010004 with BE=1111 -> user_data_out[63:32]=0xDEADBEEF; user_wr_strobe=0010 for one cycle.
- Write 0x11223344 with BE=0100 to reg 1 (holding 0xDEADBEEF) -> reg 1 = 0xDE22BEEF.
- C_RO_MASK=4'b1000, user_data_in[127:96]=0x12345678: read 0x0101000C -> 0x12345678; write there -> acked, no strobe, readback unchanged.
- Access 0x01010080 (index 32 >= C_NUM_REGS) -> acked, reads 0. Access 0x01020000 -> no ack, Sl_DBus=0.
- With shadow enabled: write reg 2 = 0x55 -> user_data_out unchanged; pulse user_commit -> reg 2 = 0x55 and strobe=0100; a second commit produces no strobe.

Source files
------------

// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank: FSM states, word shift, byte-lane mask.
package opb_regbank_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam int WORD_SHIFT = 2;

    // OPB numbers byte lanes big-endian, so BE[0] (vector MSB) covers user bits [31:24].
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{be[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/opb_regbank_slave.sv
// OPB slave front end: window decode, IDLE/ACK handshake FSM, captured access and read-data gating.
module opb_regbank_slave
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0101_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0101_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [0:C_OPB_AWIDTH-1]                opb_abus,
    input  logic [0:3]                             opb_be,
    input  logic [0:C_OPB_DWIDTH-1]                opb_dbus,
    input  logic                                   opb_rnw,
    input  logic                                   opb_select,
    input  logic [31:0]                            rd_word,
    output logic [0:C_OPB_DWIDTH-1]                sl_dbus,
    output logic                                   sl_xfer_ack,
    output logic                                   wr_en,
    output logic [C_OPB_AWIDTH-WORD_SHIFT-1:0]     acc_idx,
    output logic [31:0]                            acc_data,
    output logic [31:0]                            acc_mask
);

    localparam int IDX_W = C_OPB_AWIDTH - WORD_SHIFT;

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [C_OPB_AWIDTH-1:0] offset;
    logic [IDX_W-1:0]        hit_idx;
    logic                    hit;
    logic                    unused_offset;

    state_t           state_reg;
    logic             ack_reg;
    logic             rnw_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      data_reg;
    logic [31:0]      mask_reg;

    assign addr    = opb_abus;
    assign offset  = addr - C_BASEADDR[C_OPB_AWIDTH-1:0];
    assign hit_idx = offset[C_OPB_AWIDTH-1:WORD_SHIFT];
    assign hit     = opb_select
                  && (addr >= C_BASEADDR[C_OPB_AWIDTH-1:0])
                  && (addr <= C_HIGHADDR[C_OPB_AWIDTH-1:0]);
    assign unused_offset = ^offset[WORD_SHIFT-1:0];

    // Select is not rechecked in ACK: an aborted transfer still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            rnw_reg   <= 1'b0;
            idx_reg   <= '0;
            data_reg  <= '0;
            mask_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        state_reg <= ACK;
                        ack_reg   <= 1'b1;
                        rnw_reg   <= opb_rnw;
                        idx_reg   <= hit_idx;
                        data_reg  <= opb_dbus;
                        mask_reg  <= be_to_mask(opb_be);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign sl_xfer_ack = ack_reg;
    assign sl_dbus     = (ack_reg && rnw_reg) ? rd_word : '0;
    assign wr_en       = ack_reg && !rnw_reg;
    assign acc_idx     = idx_reg;
    assign acc_data    = data_reg;
    assign acc_mask    = mask_reg;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB register bank of C_NUM_REGS 32-bit user registers with read-only slices and write strobes.
// Define OPB_REGBANK_SHADOW_EN to stage writes in shadow registers released by user_commit.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0101_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0101_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [63:0] C_RO_MASK    = 64'h0,
    parameter logic [31:0] C_RESET_VAL  = 32'h0,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    input  logic [32*C_NUM_REGS-1:0]  user_data_in,
    output logic [C_NUM_REGS-1:0]     user_wr_strobe,
    input  logic                      user_commit
);

    localparam int    IDX_W         = C_OPB_AWIDTH - WORD_SHIFT;
    localparam string unused_family = C_FAMILY;

    logic             wr_en;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_data;
    logic [31:0]      acc_mask;
    logic [31:0]      rd_word;
    logic [31:0]      read_val [C_NUM_REGS];
    logic             unused_inputs;

    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign unused_inputs = ^{OPB_seqAddr, user_commit, user_data_in};

    opb_regbank_slave #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_OPB_DWIDTH (C_OPB_DWIDTH)
    ) u_slave (
        .clk         (OPB_Clk),
        .rst_n       (OPB_Rst_n),
        .opb_abus    (OPB_ABus),
        .opb_be      (OPB_BE),
        .opb_dbus    (OPB_DBus),
        .opb_rnw     (OPB_RNW),
        .opb_select  (OPB_select),
        .rd_word     (rd_word),
        .sl_dbus     (Sl_DBus),
        .sl_xfer_ack (Sl_xferAck),
        .wr_en       (wr_en),
        .acc_idx     (acc_idx),
        .acc_data    (acc_data),
        .acc_mask    (acc_mask)
    );

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
            if (C_RO_MASK[gi]) begin : g_ro
                logic [31:0] ro_reg;

                always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                    if (!OPB_Rst_n) ro_reg <= '0;
                    else            ro_reg <= user_data_in[32*gi +: 32];
                end

                assign user_data_out[32*gi +: 32] = ro_reg;
                assign read_val[gi]               = user_data_in[32*gi +: 32];
                assign user_wr_strobe[gi]         = 1'b0;
            end else begin : g_rw
                logic wr_hit;
                assign wr_hit = wr_en && (acc_idx == IDX_W'(gi));
`ifdef OPB_REGBANK_SHADOW_EN
                logic [31:0] shadow_reg;
                logic [31:0] out_reg;
                logic        dirty_reg;
                logic        strobe_reg;

                // A write coinciding with a commit keeps its register dirty; out_reg takes the old shadow.
                always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                    if (!OPB_Rst_n) begin
                        shadow_reg <= C_RESET_VAL;
                        out_reg    <= C_RESET_VAL;
                        dirty_reg  <= 1'b0;
                        strobe_reg <= 1'b0;
                    end else begin
                        if (wr_hit)
                            shadow_reg <= (shadow_reg & ~acc_mask) | (acc_data & acc_mask);
                        if (user_commit)
                            out_reg <= shadow_reg;
                        dirty_reg  <= wr_hit || (dirty_reg && !user_commit);
                        strobe_reg <= user_commit && dirty_reg;
                    end
                end

                assign user_data_out[32*gi +: 32] = out_reg;
                assign read_val[gi]               = shadow_reg;
                assign user_wr_strobe[gi]         = strobe_reg;
`else
                logic [31:0] data_reg;
                logic        strobe_reg;

                always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                    if (!OPB_Rst_n) begin
                        data_reg   <= C_RESET_VAL;
                        strobe_reg <= 1'b0;
                    end else begin
                        if (wr_hit)
                            data_reg <= (data_reg & ~acc_mask) | (acc_data & acc_mask);
                        strobe_reg <= wr_hit;
                    end
                end

                assign user_data_out[32*gi +: 32] = data_reg;
                assign read_val[gi]               = data_reg;
                assign user_wr_strobe[gi]         = strobe_reg;
`endif
            end
        end
    endgenerate

    // Indices past the populated registers read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (acc_idx == IDX_W'(i)) rd_word = read_val[i];
        end
    end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for opb_register_bank_ppc2simulink (4 regs, reg 3 read-only, reset value A5A50000).
module tb_opb_register_bank_ppc2simulink;

    logic         clk;
    logic         rst_n;
    logic [0:31]  abus;
    logic [0:3]   be;
    logic [0:31]  dbus;
    logic         rnw;
    logic         select;
    logic         seq_addr;
    logic [0:31]  sl_dbus;
    logic         xfer_ack;
    logic         err_ack;
    logic         retry;
    logic         tout_sup;
    logic [127:0] udo;
    logic [127:0] udi;
    logic [3:0]   stb;
    logic         commit;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    localparam logic [31:0] RV = 32'hA5A5_0000;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR   (32'h0101_0000),
        .C_HIGHADDR   (32'h0101_00FF),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_REGS   (4),
        .C_RO_MASK    (64'h8),
        .C_RESET_VAL  (RV),
        .C_FAMILY     ("virtex6")
    ) dut (
        .OPB_Clk        (clk),
        .OPB_Rst_n      (rst_n),
        .OPB_ABus       (abus),
        .OPB_BE         (be),
        .OPB_DBus       (dbus),
        .OPB_RNW        (rnw),
        .OPB_select     (select),
        .OPB_seqAddr    (seq_addr),
        .Sl_DBus        (sl_dbus),
        .Sl_xferAck     (xfer_ack),
        .Sl_errAck      (err_ack),
        .Sl_retry       (retry),
        .Sl_toutSup     (tout_sup),
        .user_data_out  (udo),
        .user_data_in   (udi),
        .user_wr_strobe (stb),
        .user_commit    (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %s: observed %0h", tag, obs);
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus transfer; select is dropped right after the ack. Cycle 1 is the first select cycle.
    task automatic bus_xfer(input logic [31:0] addr, input logic r, input logic [3:0] b,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output int ack_cyc, output int ack_cnt,
                            output logic [3:0] s3, output logic [3:0] s4, output logic [31:0] dor);
        @(posedge clk); #1;
        abus = addr; rnw = r; be = b; dbus = wdata; select = 1'b1;
        rdata = '0; ack_cyc = -1; ack_cnt = 0; s3 = '0; s4 = '0; dor = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (xfer_ack) begin
                ack_cnt++;
                if (ack_cyc < 0) begin
                    ack_cyc = c;
                    rdata   = sl_dbus;
                end
                select = 1'b0;
            end else begin
                dor = dor | sl_dbus;
            end
            if (c == 3) s3 = stb;
            if (c == 4) s4 = stb;
        end
        $display("xfer addr=%08h rnw=%0b be=%04b wdata=%08h rdata=%08h ack_cyc=%0d acks=%0d",
                 addr, r, b, wdata, rdata, ack_cyc, ack_cnt);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] dor;
        logic [3:0]  s3;
        logic [3:0]  s4;
        int          ac;
        int          an;
        int          n;

        rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b1;
        select = 1'b0; seq_addr = 1'b0; commit = 1'b0;
        udi = {32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        repeat (2) @(negedge clk);
        check("rst_ack", xfer_ack, 0);
        check("rst_dbus", sl_dbus, 0);
        check("rst_strobe", stb, 0);
        check("rst_udo", udo, {32'h0, RV, RV, RV});
        check("tied_outputs", {err_ack, retry, tout_sup}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset-value readback with latency and single-ack checks
        for (int i = 0; i < 3; i++) begin
            bus_xfer(32'h0101_0000 + 32'(4*i), 1'b1, 4'hF, 32'h0, rd, ac, an, s3, s4, dor);
            check($sformatf("rd%0d_val", i), rd, RV);
            check($sformatf("rd%0d_ack_cycle", i), ac, 2);
            check($sformatf("rd%0d_ack_count", i), an, 1);
            check($sformatf("rd%0d_dbus_idle_zero", i), dor, 0);
        end

        bus_xfer(32'h0101_0004, 1'b0, 4'b1111, 32'hDEAD_BEEF, rd, ac, an, s3, s4, dor);
        check("wr1_ack_count", an, 1);
        check("wr1_strobe", s3, 4'b0010);
        check("wr1_strobe_off", s4, 4'b0000);
        check("wr1_udo", udo[63:32], 32'hDEAD_BEEF);

        bus_xfer(32'h0101_0004, 1'b0, 4'b0100, 32'h1122_3344, rd, ac, an, s3, s4, dor);
        check("wr1_be0100_udo", udo[63:32], 32'hDE22_BEEF);
        bus_xfer(32'h0101_0004, 1'b1, 4'b0000, 32'h0, rd, ac, an, s3, s4, dor);
        check("wr1_be0100_read", rd, 32'hDE22_BEEF);

        bus_xfer(32'h0101_0000, 1'b0, 4'b0000, 32'hFFFF_FFFF, rd, ac, an, s3, s4, dor);
        check("be0000_ack_count", an, 1);
        check("be0000_strobe", s3, 4'b0001);
        check("be0000_udo", udo[31:0], RV);

        bus_xfer(32'h0101_000C, 1'b1, 4'hF, 32'h0, rd, ac, an, s3, s4, dor);
        check("ro_read", rd, 32'h1234_5678);
        check("ro_udo_copy", udo[127:96], 32'h1234_5678);
        bus_xfer(32'h0101_000C, 1'b0, 4'hF, 32'hCAFE_F00D, rd, ac, an, s3, s4, dor);
        check("ro_write_ack_count", an, 1);
        check("ro_write_strobe", s3, 4'b0000);
        bus_xfer(32'h0101_000C, 1'b1, 4'hF, 32'h0, rd, ac, an, s3, s4, dor);
        check("ro_readback", rd, 32'h1234_5678);

        bus_xfer(32'h0101_0080, 1'b0, 4'hF, 32'hFFFF_FFFF, rd, ac, an, s3, s4, dor);
        check("oob_write_ack_count", an, 1);
        check("oob_write_strobe", s3, 4'b0000);
        bus_xfer(32'h0101_0080, 1'b1, 4'hF, 32'h0, rd, ac, an, s3, s4, dor);
        check("oob_read_ack_count", an, 1);
        check("oob_read_val", rd, 0);

        bus_xfer(32'h0102_0000, 1'b1, 4'hF, 32'h0, rd, ac, an, s3, s4, dor);
        check("miss_ack_count", an, 0);
        check("miss_dbus", dor, 0);

        // Select held for six cycles: acks in cycles 2, 4 and 6
        @(posedge clk); #1;
        abus = 32'h0101_0004; rnw = 1'b1; be = 4'hF; select = 1'b1; n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (xfer_ack) n++;
        end
        @(posedge clk); #1 select = 1'b0;
        check("b2b_ack_count", n, 3);

        // Reset during the ACK cycle of a write: ack vanishes, register returns to reset value
        @(posedge clk); #1;
        abus = 32'h0101_0004; rnw = 1'b0; be = 4'hF; dbus = 32'h0BAD_0BAD; select = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0; select = 1'b0;
        @(negedge clk);
        check("midrst_ack", xfer_ack, 0);
        check("midrst_udo", udo[63:32], RV);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_after_strobe", stb, 0);
        check("midrst_after_udo", udo[63:32], RV);

`ifdef OPB_REGBANK_SHADOW_EN
        bus_xfer(32'h0101_0008, 1'b0, 4'hF, 32'h0000_0055, rd, ac, an, s3, s4, dor);
        check("sh_wr_udo_held", udo[95:64], RV);
        check("sh_wr_no_strobe", s3, 4'b0000);
        bus_xfer(32'h0101_0008, 1'b1, 4'hF, 32'h0, rd, ac, an, s3, s4, dor);
        check("sh_readback", rd, 32'h0000_0055);
        @(posedge clk); #1 commit = 1'b1;
        @(posedge clk); #1 commit = 1'b0;
        @(negedge clk);
        check("sh_commit_strobe", stb, 4'b0100);
        check("sh_commit_udo", udo[95:64], 32'h0000_0055);
        @(negedge clk);
        check("sh_commit_strobe_off", stb, 4'b0000);
        @(posedge clk); #1 commit = 1'b1;
        @(posedge clk); #1 commit = 1'b0;
        @(negedge clk);
        check("sh_recommit_strobe", stb, 4'b0000);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
